// File: rtl/disp_seq_ctrl.sv
// Display refresh sequencer: a prescaler paces frames; each frame loads N_CH
// channels into a downstream shift register one at a time, then latches the display.
module disp_seq_ctrl #(
  parameter int N_CH     = 5,
  parameter int MUXSEL_W = 3,
  parameter int SCALER_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [1:0]          i_rate,
  input  logic                i_srbusy,
  output logic                o_srload,
  output logic [MUXSEL_W-1:0] o_muxsel,
  output logic                o_latch,
  output logic                o_tick,
  output logic                o_frame_done,
  output logic                o_overrun,
  output logic                o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NEXT,
    S_DRAIN,
    S_LATCH
  } state_t;

  localparam logic [MUXSEL_W-1:0] LAST_CH = MUXSEL_W'(N_CH - 1);

  state_t              state_q, state_d;
  logic [MUXSEL_W-1:0] chan_q, chan_d;
  logic [SCALER_W-1:0] scaler_q, scaler_d, scaler_lim;
  logic                tick;

  always_comb begin
    case (i_rate)
      2'd0:    scaler_lim = SCALER_W'(127);
      2'd1:    scaler_lim = SCALER_W'(255);
      2'd2:    scaler_lim = SCALER_W'(511);
      default: scaler_lim = SCALER_W'(1023);
    endcase
  end

  // >= rather than == so a shrinking divisor never lets the count run away
  assign scaler_d = (scaler_q >= scaler_lim) ? '0 : scaler_q + SCALER_W'(1);
  assign tick     = (scaler_q == '0);

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      S_IDLE: begin
        chan_d = '0;
        if (i_en && tick) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!i_srbusy) state_d = S_NEXT;
      end
      S_NEXT: begin
        // busy only rises after the load strobe, so it is not looked at here
        if (chan_q == LAST_CH) begin
          state_d = S_DRAIN;
        end else begin
          chan_d  = chan_q + MUXSEL_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (!i_srbusy) state_d = S_LATCH;
      end
      S_LATCH: begin
        chan_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        chan_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      chan_q   <= '0;
      scaler_q <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      scaler_q <= scaler_d;
    end
  end

  // Strobes come from registered state only; a tick seen outside IDLE is a lost frame
  assign o_srload     = (state_q == S_NEXT);
  assign o_latch      = (state_q == S_LATCH);
  assign o_frame_done = (state_q == S_LATCH);
  assign o_busy       = (state_q != S_IDLE);
  assign o_overrun    = tick && (state_q != S_IDLE);
  assign o_tick       = tick;
  assign o_muxsel     = chan_q;

endmodule

// File: doc/disp_seq_ctrl.md
DISP_SEQ_CTRL -- requirements
Module: disp_seq_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 5: number of mux channels per frame, legal range 2..2^MUXSEL_W.
REQ-002 SHALL have parameter MUXSEL_W, default 3: width of the channel index.
REQ-003 SHALL have parameter SCALER_W, default 10: prescaler width, minimum 10.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port i_en, input, 1: frame start enable.
REQ-007 SHALL have port i_rate, input, 2: refresh divisor select, D = 2^(7+i_rate), i.e. 128/256/512/1024.
REQ-008 SHALL have port i_srbusy, input, 1: downstream shift register busy.
REQ-009 SHALL have port o_srload, output, 1: one-cycle load strobe to the shift register.
REQ-010 SHALL have port o_muxsel, output, MUXSEL_W: current channel index.
REQ-011 SHALL have port o_latch, output, 1: one-cycle display latch strobe.
REQ-012 SHALL have port o_tick, output, 1: prescaler tick.
REQ-013 SHALL have port o_frame_done, output, 1: one-cycle end-of-frame pulse.
REQ-014 SHALL have port o_overrun, output, 1: one-cycle pulse, tick lost during an active frame.
REQ-015 SHALL have port o_busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-016 Prescaler SHALL count 0..D-1 and wrap to 0; wrap condition is scaler >= D-1, so a downward i_rate change with scaler already past the new D-1 wraps on the next cycle.
REQ-017 o_tick SHALL be combinational (scaler == 0), independent of i_en and FSM state.
REQ-018 FSM SHALL have states IDLE, LOAD, NEXT, DRAIN, LATCH.
REQ-019 IDLE: channel counter held at 0; when i_en && o_tick, go to LOAD.
REQ-020 LOAD: wait while i_srbusy = 1; when i_srbusy = 0, go to NEXT.
REQ-021 NEXT: o_srload = 1 for exactly this one cycle; if counter == N_CH-1, go to DRAIN; else counter +1 and go to LOAD.
REQ-022 DRAIN: wait while i_srbusy = 1; when i_srbusy = 0, go to LATCH.
REQ-023 LATCH: o_latch = 1 and o_frame_done = 1 for this one cycle; next state is IDLE.
REQ-024 o_muxsel SHALL equal the channel counter at all times; it is stable from entry to LOAD through the matching NEXT cycle.
REQ-025 Downstream contract: i_srbusy rises the cycle after o_srload; the block SHALL NOT sample i_srbusy in the NEXT cycle.
REQ-026 o_srload, o_latch, o_frame_done, o_busy and o_overrun SHALL be decoded from registered state only (glitch-free, no input paths).
REQ-027 Tick with i_en = 1 while state != IDLE SHALL be dropped, not queued, and SHALL raise o_overrun for that cycle; the frame in progress is unaffected.
REQ-028 i_en deasserted mid-frame SHALL NOT abort the frame; the FSM completes through LATCH, then stays in IDLE.
REQ-029 Tick and LATCH in the same cycle: the FSM goes to IDLE, the tick is lost, and o_overrun = 1.
REQ-030 Counter SHALL never exceed N_CH-1, and SHALL NOT wrap within a frame.

Reset
REQ-031 i_rst = 1 SHALL force: state IDLE, counter 0, scaler 0; o_srload, o_latch, o_frame_done, o_overrun, o_busy all 0; o_muxsel 0; o_tick 1.
REQ-032 Reset SHALL take priority over all other updates in the same cycle, including mid-frame; no o_latch is issued for an aborted frame.
REQ-033 The first tick after reset release SHALL be at the first cycle (scaler == 0); a frame starts if i_en = 1.

Verification
REQ-034 N_CH=5, i_rate=0, i_en=1, i_srbusy always 0 -> per frame 5 o_srload pulses with o_muxsel 0,1,2,3,4, then o_latch + o_frame_done once; frame start every 128 cycles.
REQ-035 i_srbusy held high 3 cycles after each o_srload -> each LOAD waits exactly 3 cycles; o_srload count stays 5; o_latch only after the final busy falls.
REQ-036 Switch i_rate from 3 to 0 while scaler = 600 -> scaler wraps to 0 next cycle; following ticks 128 cycles apart.
REQ-037 i_srbusy stuck high for over 128 cycles mid-frame -> o_overrun pulses on each tick; no extra o_srload; the frame completes once busy drops.
REQ-038 Assert i_rst in DRAIN -> next cycle all outputs at reset values, no o_latch; normal frame resumes from channel 0.
REQ-039 i_en dropped in the cycle after frame start -> frame completes with o_frame_done; no further frames while i_en = 0.
